// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame shape and
// the oversample tick divisor helper reused by the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  function automatic int unsigned tick_div(input int unsigned clock_rate,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: one-clock tick every TICK_DIV clocks, forced
// back to zero (and silent) while restart is asserted.
module uart_sample_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = !restart && (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, recovers start/data/stop frames with an
// oversampling tick and presents bytes on a valid/ready port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 200_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned TICK_DIV = tick_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  if (TICK_DIV < 1) begin : g_chk_div
    $error("uart_rx: CLOCK_RATE too low for BAUD_RATE*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_db
    $error("uart_rx: DATA_BITS must be 5..9");
  end

  logic rx_meta, rx_s, rx_s_d;
  logic fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d && !rx_s;

  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 tick, tick_restart;

  // Holding the divider in reset through IDLE makes the first tick land a
  // fixed distance after the detected start edge.
  assign tick_restart = (state_q == RX_IDLE);

  uart_sample_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(tick_restart),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q && !rx_ready;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        os_cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_cnt_d  = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            // Shifting in at the MSB leaves the first (LSB) bit at index 0.
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_d = RX_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            state_d  = RX_IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              oerr_d  = valid_q && !rx_ready;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = (state_q != RX_IDLE);

endmodule
